// File: rtl/lbm_stream_sel.sv
// Raster-scan sequencer that feeds the LBM streaming select mux: it registers the three candidate values and the mux code.
// Define LBM_STREAM_SEL_STATS_EN to add the per-sweep wall_count output.
module lbm_stream_sel #(
  parameter int DATA_WIDTH = 64,
  parameter int NX         = 16,
  parameter int NY         = 16,
  parameter int XW         = $clog2(NX),
  parameter int YW         = $clog2(NY)
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] f_stream,
  input  logic signed [DATA_WIDTH-1:0] f_bounce,
  input  logic signed [DATA_WIDTH-1:0] f_inlet,
  input  logic                         wall_flag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] Din0,
  output logic signed [DATA_WIDTH-1:0] Din1,
  output logic signed [DATA_WIDTH-1:0] Din2,
  output logic [1:0]                   select,
  output logic [XW-1:0]                node_x,
  output logic [YW-1:0]                node_y,
  output logic                         busy,
  output logic                         done
`ifdef LBM_STREAM_SEL_STATS_EN
  ,
  output logic [$clog2(NX*NY+1)-1:0]   wall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_INTERIOR = 2'b00;
  localparam logic [1:0] SEL_BOUNCE   = 2'b01;
  localparam logic [1:0] SEL_INLET    = 2'b10;

  state_t        state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept;
  logic          consume;
  logic          x_last;
  logic          last_node;
  logic          sweep_start;
  logic [1:0]    sel_nxt;

  // The output stage accepts a new node whenever it is empty or being emptied this cycle.
  assign in_ready    = Reset_n && (state == RUN) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign consume     = out_valid && out_ready;
  assign x_last      = (x == XW'(NX - 1));
  assign last_node   = x_last && (y == YW'(NY - 1));
  assign sweep_start = start && ((state == IDLE) || (state == DONE));
  assign busy        = (state == RUN) || (state == DRAIN);

  // Wall takes priority over the inlet column.
  always_comb begin
    sel_nxt = SEL_INTERIOR;
    if (wall_flag)      sel_nxt = SEL_BOUNCE;
    else if (x == '0)   sel_nxt = SEL_INLET;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_node) state_nxt = DRAIN;
      DRAIN:   if (consume) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      Din0      <= '0;
      Din1      <= '0;
      Din2      <= '0;
      select    <= SEL_INTERIOR;
      node_x    <= '0;
      node_y    <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && consume;

      if (sweep_start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        if (last_node) begin
          x <= '0;
          y <= '0;
        end else if (x_last) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end

      // A same-cycle consume and accept simply overwrites the stage.
      if (accept) begin
        Din0      <= f_stream;
        Din1      <= f_bounce;
        Din2      <= f_inlet;
        select    <= sel_nxt;
        node_x    <= x;
        node_y    <= y;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LBM_STREAM_SEL_STATS_EN
  localparam int WCW = $clog2(NX*NY+1);

  always_ff @(posedge Clk) begin
    if (!Reset_n)               wall_count <= '0;
    else if (sweep_start)       wall_count <= '0;
    else if (accept && wall_flag) wall_count <= wall_count + WCW'(1);
  end
`endif

endmodule

// File: tb/tb_lbm_stream_sel.sv
// Self-checking bench for lbm_stream_sel: directed table sweep, corner-case sequences and randomized sweeps
// checked against a node-index scoreboard model.
module tb_lbm_stream_sel;

  localparam int NX = 4;
  localparam int NY = 3;
  localparam int N  = NX * NY;

  logic        Clk = 1'b0;
  logic        Reset_n, start, in_valid, out_ready, wall_flag;
  logic        in_ready, out_valid, busy, done;
  logic [63:0] f_stream, f_bounce, f_inlet, Din0, Din1, Din2;
  logic [1:0]  select, node_x, node_y;
`ifdef LBM_STREAM_SEL_STATS_EN
  logic [3:0]  wall_count;
`endif

  lbm_stream_sel #(.DATA_WIDTH(64), .NX(NX), .NY(NY)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .f_stream(f_stream), .f_bounce(f_bounce), .f_inlet(f_inlet), .wall_flag(wall_flag),
    .out_valid(out_valid), .out_ready(out_ready), .Din0(Din0), .Din1(Din1), .Din2(Din2),
    .select(select), .node_x(node_x), .node_y(node_y), .busy(busy), .done(done)
`ifdef LBM_STREAM_SEL_STATS_EN
    , .wall_count(wall_count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: node index k, queue of expected outputs ----------------
  typedef struct {
    logic [63:0] d0, d1, d2;
    logic [1:0]  sel;
    int          x, y;
  } exp_t;

  exp_t  q[$];
  int    k = 0;
  bit    running = 0;
  bit    done_pend = 0;
  bit    mon_en = 0;
  int    n_consumed = 0;
  bit    hold_pend = 0;
  logic [197:0] snap;

  always @(negedge Clk) begin
    if (mon_en) begin
      exp_t e;
      bit   exp_ir, was_running;
      was_running = running;
      exp_ir = Reset_n && running && (k < N) && (q.size() == 0 || out_ready);
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, exp_ir);
      check("done", done, done_pend);
      check("busy", busy, running);
      if (hold_pend)
        check("hold_stable", snap == {Din0, Din1, Din2, select, node_x, node_y}, 1);
      hold_pend = Reset_n && out_valid && !out_ready;
      snap = {Din0, Din1, Din2, select, node_x, node_y};
      done_pend = 0;
      if (!Reset_n) begin
        q.delete();
        k = 0;
        running = 0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          e = q.pop_front();
          n_consumed++;
          check("Din0", Din0, e.d0);
          check("Din1", Din1, e.d1);
          check("Din2", Din2, e.d2);
          check("select", select, e.sel);
          check("node_x", node_x, e.x);
          check("node_y", node_y, e.y);
          if (e.x == NX - 1 && e.y == NY - 1) begin
            done_pend = 1;
            running = 0;
          end
        end
        if (exp_ir && in_valid) begin
          e.d0 = f_stream; e.d1 = f_bounce; e.d2 = f_inlet;
          e.x = k % NX;    e.y = k / NX;
          e.sel = wall_flag ? 2'b01 : (e.x == 0 ? 2'b10 : 2'b00);
          q.push_back(e);
          k++;
        end
        if (start && !was_running) begin
          running = 1;
          k = 0;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input bit w);
    in_valid  = v;
    out_ready = r;
    wall_flag = w;
    f_stream  = {$urandom, $urandom};
    f_bounce  = {$urandom, $urandom};
    f_inlet   = {$urandom, $urandom};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: full rate, no walls; 1: random handshakes and walls; 2: walls at (1,1) and (3,2)
  task automatic run_sweep(input int mode, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin seen = 1; break; end
      case (mode)
        0:       drive(1, 1, 0);
        1:       drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        default: drive(1, 1, k == 5 || k == 11);
      endcase
      step();
    end
    check("sweep_done_seen", seen, 1);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        wall;
    logic [63:0] fs, fb, fi;
    logic [1:0]  exp_sel;
    logic [1:0]  exp_x, exp_y;
  } vec_t;

  vec_t tbl[N];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wall_flag = 1'b0;
    f_stream = '0; f_bounce = '0; f_inlet = '0;

    for (int i = 0; i < N; i++) begin
      tbl[i].wall    = 1'b0;
      tbl[i].fs      = {$urandom, $urandom};
      tbl[i].fb      = {$urandom, $urandom};
      tbl[i].fi      = {$urandom, $urandom};
      tbl[i].exp_sel = (i % NX == 0) ? 2'b10 : 2'b00;
      tbl[i].exp_x   = 2'(i % NX);
      tbl[i].exp_y   = 2'(i / NX);
    end
    tbl[4].wall    = 1'b1;
    tbl[4].fb      = 64'hFFFF_FFFF_FFFF_FFFB;
    tbl[4].exp_sel = 2'b01;

    // reset state
    step();
    Reset_n = 1'b1;
    mon_en = 1;
    check("rst_out_valid", out_valid, 0);
    check("rst_Din0", Din0, 0);
    check("rst_select", select, 0);
    check("rst_node_xy", {node_x, node_y}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_in_ready", in_ready, 0);

    // directed full-rate sweep from the table
    pulse_start();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      wall_flag = tbl[i].wall;
      f_stream = tbl[i].fs; f_bounce = tbl[i].fb; f_inlet = tbl[i].fi;
      step();
      check("tbl_valid", out_valid, 1);
      check("tbl_select", select, tbl[i].exp_sel);
      check("tbl_x", node_x, tbl[i].exp_x);
      check("tbl_y", node_y, tbl[i].exp_y);
      check("tbl_Din1", Din1, tbl[i].fb);
    end
    check("tbl_done_early", done, 0);
    in_valid = 1'b0; wall_flag = 1'b0;
    step();
    check("tbl_done_pulse", done, 1);
    step();
    check("tbl_done_clear", done, 0);
    check("tbl_done_state", {busy, out_valid}, 0);

    // backpressure at node (2,0)
    n_consumed = 0;
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      if (out_valid && node_x == 2 && node_y == 0) break;
      drive(1, 1, 0);
      if (k == 2) f_stream = 64'h7FFF_0000_0000_0001;
      step();
    end
    check("bp_reached", {node_y, node_x}, {2'd0, 2'd2});
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", in_ready, 0);
      step();
      check("bp_Din0", Din0, 64'h7FFF_0000_0000_0001);
      check("bp_node_x", node_x, 2);
    end
    run_sweep(0, 40);
    check("bp_count", n_consumed, N);

    // reset after 5 accepts aborts the sweep
    pulse_start();
    for (int c = 0; c < 20 && k < 5; c++) begin
      drive(1, 1, 0);
      step();
    end
    check("mid_k", k, 5);
    in_valid = 1'b0;
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    check("mid_rst_outs", {out_valid, select, node_x, node_y, busy, done, in_ready}, 0);
    check("mid_rst_data", Din0 | Din1 | Din2, 0);
    step(); step();
    n_consumed = 0;
    pulse_start();
    run_sweep(1, 300);
    check("after_rst_count", n_consumed, N);

    // start during RUN is ignored; start in DONE restarts at (0,0)
    n_consumed = 0;
    pulse_start();
    for (int c = 0; c < 20 && k < 6; c++) begin
      drive(1, 1, 0);
      step();
    end
    start = 1'b1;
    drive(1, 1, 0);
    step();
    start = 1'b0;
    check("run_start_k", k, 7);
    run_sweep(0, 40);
    check("run_start_count", n_consumed, N);
    step();
    pulse_start();
    drive(1, 1, 0);
    step();
    check("restart_xy", {out_valid, node_y, node_x}, {1'b1, 2'd0, 2'd0});
    run_sweep(0, 40);

    // randomized sweeps
    for (int s = 0; s < 4; s++) begin
      n_consumed = 0;
      step();
      pulse_start();
      run_sweep(1, 400);
      check("rand_count", n_consumed, N);
    end

`ifdef LBM_STREAM_SEL_STATS_EN
    step();
    pulse_start();
    run_sweep(2, 40);
    step();
    check("wall_count_done", wall_count, 2);
    pulse_start();
    check("wall_count_clear", wall_count, 0);
    run_sweep(0, 40);
`endif

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lbm_stream_sel.md
Name: lbm_stream_sel

Overview:
- Sequencer directly upstream of the 3-input signed selection mux (Din0/Din1/Din2/select -> Dout) in the LBM streaming path.
- Scans the NX x NY lattice in raster order, one distribution value per node.
- Classifies each node as interior, wall or inlet, and presents the three candidate values plus a registered 2-bit select, cycle-aligned.
- Valid/ready handshake on both sides; a single output register stage.

Parameters:
- DATA_WIDTH, 64, width of the signed distribution values
- NX, 16, lattice width in nodes (>=2)
- NY, 16, lattice height in nodes (>=1)
- XW, $clog2(NX), width of the x coordinate
- YW, $clog2(NY), width of the y coordinate

Ports:
- Clk  input  1  system clock, rising edge
- Reset_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a sweep when IDLE or DONE
- in_valid  input  1  upstream node data valid
- in_ready  output  1  block accepts node data this cycle
- f_stream  input  DATA_WIDTH  signed streamed neighbour value
- f_bounce  input  DATA_WIDTH  signed bounce-back (opposite direction) value
- f_inlet  input  DATA_WIDTH  signed fixed inlet value
- wall_flag  input  1  current node is solid
- out_valid  output  1  Din0..Din2/select valid
- out_ready  input  1  downstream consumes this cycle
- Din0  output  DATA_WIDTH  registered f_stream
- Din1  output  DATA_WIDTH  registered f_bounce
- Din2  output  DATA_WIDTH  registered f_inlet
- select  output  2  mux code for the registered node
- node_x  output  XW  x of the registered node
- node_y  output  YW  y of the registered node
- busy  output  1  state is RUN or DRAIN
- done  output  1  one-cycle pulse when the last node is consumed

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-low on Reset_n.
- Reset (Reset_n=0 at a rising edge):
  - State goes to IDLE.
  - Cleared to 0: out_valid, Din0..Din2, select, node_x, node_y, the x/y counters, busy, done.
  - in_ready is 0 while in reset.
  - Reset asserted mid-sweep aborts the sweep; no done pulse is produced.
- States:
  - IDLE: in_ready=0. start -> RUN; counters are set to x=0, y=0.
  - RUN: in_ready = !out_valid || out_ready.
    - An accept is the cycle with in_valid && in_ready.
    - On accept: load Din0<=f_stream, Din1<=f_bounce, Din2<=f_inlet, node_x<=x, node_y<=y, and set out_valid<=1.
    - On accept: x increments; at x==NX-1, x wraps to 0 and y increments.
    - When the accepted node is (NX-1, NY-1), go to DRAIN.
  - DRAIN: in_ready=0. When out_valid && out_ready, pulse done for one cycle and go to DONE.
  - DONE: in_ready=0, out_valid=0. start -> RUN with counters at 0. Otherwise hold.
- Select encoding, registered with the data:
  - wall_flag=1 -> 2'b01 (bounce-back). Wall has priority over inlet.
  - else x==0 -> 2'b10 (inlet column).
  - else -> 2'b00 (interior).
  - 2'b11 is never driven.
- Output handshake:
  - When out_valid && !out_ready, all registered outputs hold stable.
  - When out_valid && out_ready with no new accept in the same cycle, out_valid goes to 0.
  - A same-cycle consume and accept replaces the data, so the block sustains full throughput of one node per cycle.
- Latency: one cycle from accept to out_valid.
- The out_valid is cleared by a consume only; no other event drops it while in RUN or DRAIN.
- start received while in RUN or DRAIN is ignored.
- Data is passed through bit-exact; no sign extension or arithmetic on the values.
- Total nodes accepted per sweep is exactly NX*NY.

Optional Feature:
- Macro: LBM_STREAM_SEL_STATS_EN.
- Defined:
  - Adds output port wall_count, width $clog2(NX*NY+1).
  - Counts accepted nodes with wall_flag=1 in the current sweep.
  - Cleared to 0 on reset and on sweep start (start accepted in IDLE or DONE).
  - Holds its final value in DONE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Bench parameters: NX=4, NY=3, DATA_WIDTH=64 for all scenarios.
- Reset then start, in_valid=1 and out_ready=1 constant, wall_flag=0 -> 12 outputs, one per cycle.
  - select=10 at x=0, 00 otherwise.
  - node_x/node_y raster order 0..3 / 0..2.
  - done pulses exactly once, 1 cycle after the 12th output is consumed.
- Node (0,1) with wall_flag=1 and f_bounce=-5 -> select=01, Din1=64'hFFFF_FFFF_FFFF_FFFB. Confirms wall beats inlet.
- Backpressure: out_ready=0 for 3 cycles at node (2,0) with f_stream=0x7FFF_0000_0000_0001.
  - in_ready=0 throughout, outputs held stable.
  - Resumes with no node lost or duplicated.
- Reset_n=0 for one cycle after 5 nodes accepted -> all outputs 0, state IDLE, no done.
  - A subsequent start gives a full 12-node sweep.
- start pulsed during RUN -> ignored; counters unaffected.
  - A start in DONE restarts at (0,0).
- With LBM_STREAM_SEL_STATS_EN defined, walls at (1,1) and (3,2) -> wall_count=2 in DONE.
  - wall_count reads 0 the cycle after the next start.
